// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding, parity codes and the parity helper.
// Used by uart_tx and the future uart_rx.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      DATA  = 3'd2,
      PAR   = 3'd3,
      STOP  = 3'd4
   } uart_state_e;

   localparam int PAR_NONE = 0;
   localparam int PAR_ODD  = 1;
   localparam int PAR_EVEN = 2;

   // Zero padding above the data width does not change the XOR reduction.
   function automatic logic parity_bit(input logic [8:0] word, input int mode);
      return (mode == PAR_ODD) ? ~^word : ^word;
   endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO, power-of-two depth, registered occupancy; pointers wrap naturally.
// Push when full and pop when empty are ignored.
module uart_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic [WIDTH-1:0]           din,
   input  logic                       pop,
   output logic [WIDTH-1:0]           dout,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     level
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [AW-1:0]    wr_ptr_r;
   logic [AW-1:0]    rd_ptr_r;
   logic [AW:0]      level_r;
   logic             push_s;
   logic             pop_s;

   assign push_s = push && !full;
   assign pop_s  = pop && !empty;
   assign full   = (level_r == (AW+1)'(DEPTH));
   assign empty  = (level_r == '0);
   assign dout   = mem_r[rd_ptr_r];
   assign level  = level_r;

   // Storage array, left unreset so it can map onto RAM.
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_r[wr_ptr_r] <= din;
      end
   end

   // Pointers and occupancy.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         level_r  <= '0;
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + AW'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + AW'(1);
         end
         case ({push_s, pop_s})
            2'b10:   level_r <= level_r + (AW+1)'(1);
            2'b01:   level_r <= level_r - (AW+1)'(1);
            default: level_r <= level_r;
         endcase
      end
   end

endmodule

// File: rtl/uart_tx.sv
// Parametrised UART transmitter (start / data / optional parity / stop bits).
// Define UART_TX_FIFO_EN to place a uart_fifo in front of the frame FSM.
module uart_tx
   import uart_pkg::*;
#(
   parameter int FREQ       = 12000000,
   parameter int BAUD       = 9600,
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          stb,
   input  logic [DATA_BITS-1:0]          dat,
   output logic                          rdy,
   output logic                          txd,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   level
);

   localparam int PERIOD = FREQ / BAUD;
   localparam int DIV_W  = $clog2(PERIOD);
   localparam int IDX_W  = 4;
   localparam int LVL_W  = $clog2(FIFO_DEPTH) + 1;

   if (PERIOD < 2) begin : g_bad_period
      $error("uart_tx: FREQ/BAUD must be at least 2");
   end
   if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
      $error("uart_tx: DATA_BITS must be 5..9");
   end
   if (PARITY < PAR_NONE || PARITY > PAR_EVEN) begin : g_bad_parity
      $error("uart_tx: PARITY must be 0, 1 or 2");
   end
   if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
      $error("uart_tx: STOP_BITS must be 1 or 2");
   end
   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("uart_tx: FIFO_DEPTH must be a power of two >= 2");
   end

   uart_state_e          state_r, state_nxt_s;
   logic [DIV_W-1:0]     div_r, div_nxt_s;
   logic [IDX_W-1:0]     idx_r, idx_nxt_s;
   logic [DATA_BITS-1:0] word_r, word_nxt_s;
   logic                 par_r, par_nxt_s;
   logic                 txd_r, txd_nxt_s;
   logic                 bit_end_s;
   logic                 start_s;
   logic                 shift_s;
   logic                 avail_s;
   logic [DATA_BITS-1:0] src_word_s;

`ifdef UART_TX_FIFO_EN
   logic                 fifo_full_s;
   logic                 fifo_empty_s;
   logic [DATA_BITS-1:0] fifo_dout_s;
   logic [LVL_W-1:0]     fifo_level_s;

   // Pop coincides with the FSM entering START; full is a decode of registered occupancy.
   uart_fifo #(
      .WIDTH (DATA_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (stb && rdy),
      .din   (dat),
      .pop   (start_s),
      .dout  (fifo_dout_s),
      .full  (fifo_full_s),
      .empty (fifo_empty_s),
      .level (fifo_level_s)
   );

   assign avail_s    = !fifo_empty_s;
   assign src_word_s = fifo_dout_s;
   assign rdy        = !fifo_full_s;
   assign level      = fifo_level_s;
`else
   logic rdy_r;

   // Without storage the block only takes a word while the line is idle.
   always_ff @(posedge clk) begin
      if (rst) begin
         rdy_r <= 1'b1;
      end else begin
         rdy_r <= (state_nxt_s == IDLE);
      end
   end

   assign avail_s    = stb && rdy_r;
   assign src_word_s = dat;
   assign rdy        = rdy_r;
   assign level      = '0;
`endif

   assign bit_end_s = (div_r == DIV_W'(PERIOD - 1));
   assign busy      = (state_r != IDLE) || (level != '0);
   assign txd       = txd_r;

   // Frame sequencing: bit divider, bit/stop index and state transitions.
   always_comb begin
      state_nxt_s = state_r;
      idx_nxt_s   = idx_r;
      start_s     = 1'b0;
      shift_s     = 1'b0;
      if (state_r != IDLE && !bit_end_s) begin
         div_nxt_s = div_r + DIV_W'(1);
      end else begin
         div_nxt_s = '0;
      end
      case (state_r)
         IDLE: begin
            if (avail_s) begin
               start_s     = 1'b1;
               state_nxt_s = START;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         START: begin
            if (bit_end_s) begin
               state_nxt_s = DATA;
               idx_nxt_s   = '0;
            end else begin
               state_nxt_s = START;
            end
         end
         DATA: begin
            if (bit_end_s && idx_r == IDX_W'(DATA_BITS - 1)) begin
               state_nxt_s = (PARITY != PAR_NONE) ? PAR : STOP;
               idx_nxt_s   = '0;
            end else if (bit_end_s) begin
               idx_nxt_s = idx_r + IDX_W'(1);
               shift_s   = 1'b1;
            end else begin
               state_nxt_s = DATA;
            end
         end
         PAR: begin
            if (bit_end_s) begin
               state_nxt_s = STOP;
            end else begin
               state_nxt_s = PAR;
            end
         end
         STOP: begin
            // A waiting word chains straight into the next start bit.
            if (bit_end_s && idx_r == IDX_W'(STOP_BITS - 1)) begin
               idx_nxt_s   = '0;
               start_s     = avail_s;
               state_nxt_s = avail_s ? START : IDLE;
            end else if (bit_end_s) begin
               idx_nxt_s = idx_r + IDX_W'(1);
            end else begin
               state_nxt_s = STOP;
            end
         end
         default: begin
            state_nxt_s = IDLE;
            idx_nxt_s   = '0;
         end
      endcase
   end

   // Shift word and parity are captured once per frame, at START entry.
   always_comb begin
      if (start_s) begin
         word_nxt_s = src_word_s;
         par_nxt_s  = parity_bit(9'(src_word_s), PARITY);
      end else if (shift_s) begin
         word_nxt_s = word_r >> 1;
         par_nxt_s  = par_r;
      end else begin
         word_nxt_s = word_r;
         par_nxt_s  = par_r;
      end
   end

   // Line level for the state being entered, so txd leaves a flop.
   always_comb begin
      case (state_nxt_s)
         IDLE:    txd_nxt_s = 1'b1;
         START:   txd_nxt_s = 1'b0;
         DATA:    txd_nxt_s = word_nxt_s[0];
         PAR:     txd_nxt_s = par_nxt_s;
         STOP:    txd_nxt_s = 1'b1;
         default: txd_nxt_s = 1'b1;
      endcase
   end

   // Frame state registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
         div_r   <= '0;
         idx_r   <= '0;
         word_r  <= '0;
         par_r   <= 1'b0;
         txd_r   <= 1'b1;
      end else begin
         state_r <= state_nxt_s;
         div_r   <= div_nxt_s;
         idx_r   <= idx_nxt_s;
         word_r  <= word_nxt_s;
         par_r   <= par_nxt_s;
         txd_r   <= txd_nxt_s;
      end
   end

endmodule
